// File: rtl/video_timing.sv
// Raster timing generator: registered hsync/vsync/data_en strobes and active-area coordinates.
// Define VIDEO_TIMING_IRQ_EN to build the sticky vertical-blank interrupt flop.
module video_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic        irq_ack,
    output logic        hsync,
    output logic        vsync,
    output logic        data_en,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        line_start,
    output logic        frame_start,
    output logic        vblank_irq
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL >= 4096 || V_TOTAL >= 4096) begin : g_bad_params
            $error("video_timing: H_TOTAL and V_TOTAL must be below 4096");
        end
    endgenerate

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] hcnt, vcnt;
    logic [11:0] hcnt_nxt, vcnt_nxt;
    logic        hsync_nxt, vsync_nxt, data_en_nxt, line_start_nxt, frame_start_nxt;
    logic [11:0] xpos_nxt, ypos_nxt;
    logic        active;

    // Outputs are decoded from the current counters and registered, so they lag the counters by one cycle.
    always_comb begin
        hcnt_nxt        = '0;
        vcnt_nxt        = '0;
        hsync_nxt       = 1'b0;
        vsync_nxt       = 1'b0;
        data_en_nxt     = 1'b0;
        line_start_nxt  = 1'b0;
        frame_start_nxt = 1'b0;
        xpos_nxt        = '0;
        ypos_nxt        = '0;
        active          = 1'b0;
        if (en) begin
            hcnt_nxt = (hcnt == H_LAST) ? 12'd0 : hcnt + 12'd1;
            vcnt_nxt = vcnt;
            if (hcnt == H_LAST) begin
                vcnt_nxt = (vcnt == V_LAST) ? 12'd0 : vcnt + 12'd1;
            end
            active          = (hcnt < H_ACT) && (vcnt < V_ACT);
            hsync_nxt       = (hcnt >= HS_START) && (hcnt < HS_END);
            vsync_nxt       = (vcnt >= VS_START) && (vcnt < VS_END);
            data_en_nxt     = active;
            xpos_nxt        = active ? hcnt : 12'd0;
            ypos_nxt        = active ? vcnt : 12'd0;
            line_start_nxt  = (hcnt == 12'd0);
            frame_start_nxt = (hcnt == 12'd0) && (vcnt == 12'd0);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hcnt        <= '0;
            vcnt        <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            data_en     <= 1'b0;
            xpos        <= '0;
            ypos        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcnt        <= hcnt_nxt;
            vcnt        <= vcnt_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            data_en     <= data_en_nxt;
            xpos        <= xpos_nxt;
            ypos        <= ypos_nxt;
            line_start  <= line_start_nxt;
            frame_start <= frame_start_nxt;
        end
    end

`ifdef VIDEO_TIMING_IRQ_EN
    logic irq_set;
    assign irq_set = en && (hcnt == 12'd0) && (vcnt == V_ACT);

    // Set has priority over acknowledge; a disabled timer leaves a pending interrupt alone.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vblank_irq <= 1'b0;
        end else if (irq_set) begin
            vblank_irq <= 1'b1;
        end else if (irq_ack) begin
            vblank_irq <= 1'b0;
        end
    end
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;
    assign vblank_irq     = 1'b0;
`endif

endmodule
